palindrome_gen: RTL and testbench

PALINDROME_GEN -- requirements
Module: palindrome_gen

---
 rtl/palin_pkg.sv | 23 ++
 rtl/bcd_digit_pair_ctr.sv | 36 +++
 rtl/palindrome_gen.sv | 135 +++++++++++++
 tb/tb_palindrome_gen.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/palin_pkg.sv
// Shared types and constants for the decimal palindrome generator.
// Holds the FSM state encoding, the digit and sequence limits, and the shift-add x10 helper.
package palin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUILD,
        PRESENT,
        DONE
    } state_t;

    localparam logic [3:0]  DIGIT_MAX   = 4'd9;
    localparam int unsigned BUILD_STEPS = 4;
    localparam int unsigned NUM_VALUES  = 100;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned IDX_W       = 7;

    // Forms v*10 as v*8 + v*2 so that no multiplier is inferred.
    function automatic logic [DATA_W-1:0] times_ten(input logic [DATA_W-1:0] v);
        return (v << 3) + (v << 1);
    endfunction

endpackage

// File: rtl/bcd_digit_pair_ctr.sv
// BCD counter pair holding the outer digit a and the inner digit b of palindrome "abba".
// Digit b advances on every increment; when b wraps from 9 to 0, digit a advances.
module bcd_digit_pair_ctr
    import palin_pkg::*;
#(
    parameter logic [3:0] A_INIT = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       inc,
    output logic [3:0] dig_a,
    output logic [3:0] dig_b,
    output logic       last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_a <= A_INIT;
            dig_b <= '0;
        end else if (load) begin
            dig_a <= A_INIT;
            dig_b <= '0;
        end else if (inc) begin
            if (dig_b == DIGIT_MAX) begin
                dig_b <= '0;
                dig_a <= (dig_a == DIGIT_MAX) ? A_INIT : dig_a + 4'd1;
            end else begin
                dig_b <= dig_b + 4'd1;
            end
        end
    end

    assign last = (dig_a == DIGIT_MAX) && (dig_b == DIGIT_MAX);

endmodule

// File: rtl/palindrome_gen.sv
// Streams every 4-digit decimal palindrome "abba" in ascending order over a valid/ready port.
// Each value is built from its digits by Horner's rule, one digit per cycle, before it is presented.
module palindrome_gen
    import palin_pkg::*;
#(
    parameter bit SKIP_LEADING_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] A0        = SKIP_LEADING_ZERO ? 4'd1 : 4'd0;
    localparam logic [1:0] LAST_STEP = 2'(BUILD_STEPS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        step;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_nxt;
    logic [3:0]        dig_a;
    logic [3:0]        dig_b;
    logic [3:0]        horner_digit;
    logic              last;
    logic              accept;
    logic              ctr_load;
    logic              ctr_inc;
    logic              build_entry;

    bcd_digit_pair_ctr #(
        .A_INIT (A0)
    ) u_digits (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ctr_load),
        .inc   (ctr_inc),
        .dig_a (dig_a),
        .dig_b (dig_b),
        .last  (last)
    );

    // out_valid is high only in PRESENT, so this also ignores out_ready elsewhere.
    assign accept = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        ctr_load  = 1'b0;
        ctr_inc   = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            ctr_load  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = BUILD;
                        ctr_load  = 1'b1;
                    end
                end
                BUILD: begin
                    if (step == LAST_STEP) begin
                        state_nxt = PRESENT;
                    end
                end
                PRESENT: begin
                    if (accept) begin
                        if (last) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = BUILD;
                            ctr_inc   = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Digit order a, b, b, a: outer digit on the first and last Horner steps.
    always_comb begin
        horner_digit = (step == 2'd0 || step == LAST_STEP) ? dig_a : dig_b;
        acc_nxt      = times_ten(acc) + {{(DATA_W-4){1'b0}}, horner_digit};
    end

    assign build_entry = (state_nxt == BUILD) && (state != BUILD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step      <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt == PRESENT);
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);

            if (build_entry) begin
                acc  <= '0;
                step <= '0;
            end else if (state == BUILD && !abort) begin
                acc  <= acc_nxt;
                step <= step + 2'd1;
                if (step == LAST_STEP) begin
                    out_data <= acc_nxt;
                end
            end

            if (abort || (state == IDLE && start)) begin
                out_idx <= '0;
            end else if (accept && !last) begin
                out_idx <= out_idx + 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_palindrome_gen.sv
// Directed self-checking bench for palindrome_gen, covering both leading-digit variants.
// Expected values come from the closed form 1001*a + 110*b and hand-derived cycle counts.
module tb_palindrome_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_r = 1'b0;
    logic        abort_r = 1'b0;
    logic        ready = 1'b1;
    logic        sel = 1'b0;

    logic        start0, start1, abort0, abort1;
    logic        valid0, valid1, busy0, busy1, done0, done1;
    logic [15:0] data0, data1;
    logic [6:0]  idx0, idx1;

    logic        obs_valid, obs_busy, obs_done;
    logic [15:0] obs_data;
    logic [6:0]  obs_idx;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign start0 = start_r & ~sel;
    assign start1 = start_r & sel;
    assign abort0 = abort_r & ~sel;
    assign abort1 = abort_r & sel;

    assign obs_valid = sel ? valid1 : valid0;
    assign obs_busy  = sel ? busy1  : busy0;
    assign obs_done  = sel ? done1  : done0;
    assign obs_data  = sel ? data1  : data0;
    assign obs_idx   = sel ? idx1   : idx0;

    palindrome_gen #(.SKIP_LEADING_ZERO(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .out_ready(ready),
        .out_valid(valid0), .out_data(data0), .out_idx(idx0), .busy(busy0), .done(done0)
    );

    palindrome_gen #(.SKIP_LEADING_ZERO(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .out_ready(ready),
        .out_valid(valid1), .out_data(data1), .out_idx(idx1), .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(obs_valid), 32'd0);
        check({tag, "_data"},  32'(obs_data),  32'd0);
        check({tag, "_idx"},   32'(obs_idx),   32'd0);
        check({tag, "_busy"},  32'(obs_busy),  32'd0);
        check({tag, "_done"},  32'(obs_done),  32'd0);
    endtask

    task automatic wait_valid(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < 20 && !ok) begin
            @(negedge clk);
            start_r = 1'b0;
            n++;
            if (obs_valid) ok = 1'b1;
        end
    endtask

    // mode: 0 run to completion, 1 abort at stop_k, 2 async reset in BUILD after stop_k
    task automatic run_seq(input bit skip, input int stop_k, input int mode, input bit bp);
        int          a0;
        int          total;
        int          gap;
        bit          ok;
        int          d;
        logic [15:0] exp_v;
        a0    = skip ? 1 : 0;
        total = skip ? 90 : 100;
        sel   = skip;
        ready = 1'b1;
        @(negedge clk);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        for (int k = 0; k < total; k++) begin
            wait_valid(gap, ok);
            if (!ok) begin
                check("valid_timeout", 32'd0, 32'd1);
                return;
            end
            check(k == 0 ? "first_latency" : "gap", 32'(gap), k == 0 ? 32'd4 : 32'd5);
            exp_v = 16'(1001 * (a0 + k / 10) + 110 * (k % 10));
            check("data", 32'(obs_data), 32'(exp_v));
            check("idx", 32'(obs_idx), 32'(k));
            d = int'(obs_data);
            check("palin_digits", 32'((d / 1000 == d % 10) && ((d / 100) % 10 == (d / 10) % 10)), 32'd1);
            check("done_early", 32'(obs_done), 32'd0);
            if (k == stop_k && mode == 1) begin
                abort_r = 1'b1;
                @(negedge clk);
                abort_r = 1'b0;
                check("abort_valid", 32'(obs_valid), 32'd0);
                check("abort_busy",  32'(obs_busy),  32'd0);
                check("abort_idx",   32'(obs_idx),   32'd0);
                repeat (3) begin
                    @(negedge clk);
                    check("abort_no_done", 32'(obs_done), 32'd0);
                end
                return;
            end
            if (k == stop_k && mode == 2) begin
                repeat (2) @(negedge clk);
                #3 rst_n = 1'b0;
                #1 check_idle_outputs("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (bp && exp_v == 16'd1221) begin
                ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_valid", 32'(obs_valid), 32'd1);
                    check("bp_data",  32'(obs_data),  32'd1221);
                end
                ready = 1'b1;
            end
            if (k == 20) start_r = 1'b1;
        end
        @(negedge clk);
        check("done_pulse", 32'(obs_done),  32'd1);
        check("done_busy",  32'(obs_busy),  32'd1);
        check("done_valid", 32'(obs_valid), 32'd0);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        check("done_fall", 32'(obs_done), 32'd0);
        check("busy_fall", 32'(obs_busy), 32'd0);
        repeat (4) @(negedge clk);
        check("idle_after_done_valid", 32'(obs_valid), 32'd0);
        check("idle_after_done_busy",  32'(obs_busy),  32'd0);
    endtask

    initial begin
        #1;
        sel = 1'b0;
        #1 check_idle_outputs("reset0");
        sel = 1'b1;
        #1 check_idle_outputs("reset1");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        sel = 1'b0;
        check("post_reset_busy", 32'(obs_busy), 32'd0);

        run_seq(1'b0, -1, 0, 1'b1);
        run_seq(1'b0, 55, 1, 1'b0);
        run_seq(1'b0, 2,  1, 1'b0);
        run_seq(1'b0, 7,  2, 1'b0);
        run_seq(1'b0, 1,  1, 1'b0);
        run_seq(1'b1, -1, 0, 1'b0);
        run_seq(1'b1, 45, 1, 1'b0);
        run_seq(1'b1, 0,  1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
